// File: rtl/strip_sched.sv
// strip_sched: strip scheduler and inter-strip boundary buffer for the
// two-piece affine-gap systolic array.
//
// Each strip runs LOAD (query broadcast, N_PE cycles), CALC (one column
// beat per cycle into PE0), DRAIN (wait for the last PE to finish) and
// RST (one-cycle PE reset). The last-PE row is captured into a ring
// buffer and replayed as PE0 boundary input on the next strip. The best
// PE_end tap score and its position are tracked across the whole sequence.
//
// Ports:
//   clk, reset_i (async, active-low)
//   start_i, new_seq_i, col_len_i          : control
//   s_update_o, pe_rst_n_o                 : PE array control
//   arr_valid_o, arr_*_o, t_addr_o         : PE0 boundary beat (registered)
//   last_valid_i, last_addr_i, last_*_i    : last PE output row
//   tap_valid_i, tap_max_i, tap_x_i/y_i    : PE_end score tap
//   busy_o, strip_o, strip_done_o, err_o   : status
//   best_o, best_x_o, best_y_o             : best tap score and position
module strip_sched #(
  parameter int N_PE      = 64,
  parameter int CALC_W    = 16,
  parameter int ADDR_W    = 11,
  parameter int DEPTH     = 2048,
  parameter int MAX_STRIP = 8,
  parameter int STRIP_W   = 4,
  parameter int NEG_INF   = -1024
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              new_seq_i,
  input  logic [ADDR_W-1:0] col_len_i,
  output logic              s_update_o,
  output logic              pe_rst_n_o,
  output logic              arr_valid_o,
  output logic [CALC_W-1:0] arr_h_o,
  output logic [CALC_W-1:0] arr_f_o,
  output logic [CALC_W-1:0] arr_fh_o,
  output logic [CALC_W-1:0] arr_max_o,
  output logic [ADDR_W-1:0] arr_x_o,
  output logic [ADDR_W-1:0] arr_y_o,
  output logic [ADDR_W-1:0] arr_col_o,
  output logic [ADDR_W-1:0] t_addr_o,
  input  logic              last_valid_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  input  logic [CALC_W-1:0] last_h_i,
  input  logic [CALC_W-1:0] last_f_i,
  input  logic [CALC_W-1:0] last_fh_i,
  input  logic [CALC_W-1:0] last_max_i,
  input  logic [ADDR_W-1:0] last_x_i,
  input  logic [ADDR_W-1:0] last_y_i,
  input  logic [ADDR_W-1:0] last_col_i,
  input  logic              tap_valid_i,
  input  logic [CALC_W-1:0] tap_max_i,
  input  logic [ADDR_W-1:0] tap_x_i,
  input  logic [ADDR_W-1:0] tap_y_i,
  output logic              busy_o,
  output logic [STRIP_W-1:0] strip_o,
  output logic              strip_done_o,
  output logic              err_o,
  output logic [CALC_W-1:0] best_o,
  output logic [ADDR_W-1:0] best_x_o,
  output logic [ADDR_W-1:0] best_y_o
);

  localparam int NPE_W = $clog2(N_PE + 1);
  localparam int CNT_W = (ADDR_W > NPE_W) ? ADDR_W : NPE_W;
  localparam int RA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 4 * CALC_W + 3 * ADDR_W;
  localparam logic [CALC_W-1:0] NEG_INF_V = CALC_W'(NEG_INF);
  localparam logic [CALC_W-1:0] MOST_NEG  = {1'b1, {(CALC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, RST} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   col_len_reg;
  logic                seen_reg;
  logic [STRIP_W-1:0]  strip_reg;
  logic                err_reg;
  logic [CALC_W-1:0]   best_reg;
  logic [ADDR_W-1:0]   best_x_reg, best_y_reg;
  logic                beat_next, accept, ovf;
  logic [ADDR_W-1:0]   rd_addr;
  logic [CNT_W-1:0]    last_beat;

  // Ring buffer: written by the last PE, read one cycle ahead of each beat.
  logic [ENT_W-1:0]  ring_mem [DEPTH];
  logic [ENT_W-1:0]  wr_ent, rd_ent;
  logic [CALC_W-1:0] rd_score [4];  // h, f, fh, max
  logic [ADDR_W-1:0] rd_pos   [3];  // x, y, col

  assign wr_ent = {last_h_i, last_f_i, last_fh_i, last_max_i,
                   last_x_i, last_y_i, last_col_i};

  always_ff @(posedge clk) begin
    if (last_valid_i)
      ring_mem[last_addr_i[RA_W-1:0]] <= wr_ent;
  end

  assign rd_ent = ring_mem[rd_addr[RA_W-1:0]];

  for (genvar gi = 0; gi < 4; gi++) begin : g_score
    assign rd_score[gi] = rd_ent[ENT_W-1-gi*CALC_W -: CALC_W];
  end
  for (genvar gi = 0; gi < 3; gi++) begin : g_pos
    assign rd_pos[gi] = rd_ent[3*ADDR_W-1-gi*ADDR_W -: ADDR_W];
  end

  assign last_beat = CNT_W'(col_len_reg) - CNT_W'(1);

  // Next-state logic. beat_next/rd_addr describe the beat that will be
  // presented on the following cycle, so the read is issued one cycle early.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    beat_next  = 1'b0;
    rd_addr    = '0;
    accept     = 1'b0;
    ovf        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (strip_reg < STRIP_W'(MAX_STRIP)) begin
            accept     = 1'b1;
            state_next = LOAD;
            cnt_next   = '0;
          end else begin
            ovf = 1'b1;
          end
        end
      end
      LOAD: begin
        if (cnt_reg == CNT_W'(N_PE - 1)) begin
          state_next = CALC;
          cnt_next   = '0;
          beat_next  = (col_len_reg != '0);
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      CALC: begin
        if (col_len_reg == '0) begin
          state_next = RST;
        end else if (cnt_reg == last_beat) begin
          state_next = DRAIN;
        end else begin
          cnt_next  = cnt_reg + CNT_W'(1);
          beat_next = 1'b1;
          rd_addr   = ADDR_W'(cnt_reg + CNT_W'(1));
        end
      end
      DRAIN: begin
        if (seen_reg && !last_valid_i)
          state_next = RST;
      end
      RST:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      col_len_reg <= '0;
      seen_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept)
        col_len_reg <= col_len_i;
      // The last PE can start emitting while CALC is still issuing, so
      // activity is tracked from CALC onward and cleared during LOAD.
      if (state_reg == LOAD)
        seen_reg <= 1'b0;
      else if ((state_reg == CALC || state_reg == DRAIN) && last_valid_i)
        seen_reg <= 1'b1;
    end
  end

  // Sequence-level status: strip count, overflow flag and best tap.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      strip_reg  <= '0;
      err_reg    <= 1'b0;
      best_reg   <= MOST_NEG;
      best_x_reg <= '0;
      best_y_reg <= '0;
    end else if (new_seq_i) begin
      strip_reg  <= '0;
      err_reg    <= 1'b0;
      best_reg   <= MOST_NEG;
      best_x_reg <= '0;
      best_y_reg <= '0;
    end else begin
      if (state_reg == RST)
        strip_reg <= strip_reg + STRIP_W'(1);
      if (ovf)
        err_reg <= 1'b1;
      if (tap_valid_i && ($signed(tap_max_i) > $signed(best_reg))) begin
        best_reg   <= tap_max_i;
        best_x_reg <= tap_x_i;
        best_y_reg <= tap_y_i;
      end
    end
  end

  // Boundary output register; doubles as the ring read register.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      arr_valid_o <= 1'b0;
      t_addr_o    <= '0;
      arr_h_o     <= '0;
      arr_f_o     <= '0;
      arr_fh_o    <= '0;
      arr_max_o   <= '0;
      arr_x_o     <= '0;
      arr_y_o     <= '0;
      arr_col_o   <= '0;
    end else if (beat_next) begin
      arr_valid_o <= 1'b1;
      t_addr_o    <= rd_addr;
      if (strip_reg == '0) begin
        arr_h_o   <= '0;
        arr_f_o   <= NEG_INF_V;
        arr_fh_o  <= NEG_INF_V;
        arr_max_o <= '0;
        arr_x_o   <= '0;
        arr_y_o   <= '0;
        arr_col_o <= '0;
      end else begin
        arr_h_o   <= rd_score[0];
        arr_f_o   <= rd_score[1];
        arr_fh_o  <= rd_score[2];
        arr_max_o <= rd_score[3];
        arr_x_o   <= rd_pos[0];
        arr_y_o   <= rd_pos[1];
        arr_col_o <= rd_pos[2];
      end
    end else begin
      arr_valid_o <= 1'b0;
      t_addr_o    <= '0;
      arr_h_o     <= '0;
      arr_f_o     <= '0;
      arr_fh_o    <= '0;
      arr_max_o   <= '0;
      arr_x_o     <= '0;
      arr_y_o     <= '0;
      arr_col_o   <= '0;
    end
  end

  assign s_update_o   = (state_reg == LOAD);
  assign pe_rst_n_o   = (state_reg != RST);
  assign strip_done_o = (state_reg == RST);
  assign busy_o       = (state_reg != IDLE);
  assign strip_o      = strip_reg;
  assign err_o        = err_reg;
  assign best_o       = best_reg;
  assign best_x_o     = best_x_reg;
  assign best_y_o     = best_y_reg;

endmodule
